// File: rtl/twiddle_pkg.sv
// Shared definitions for the twiddle table writer: FSM states, CORDIC constants,
// the arctangent table in turn units and Q1.15 saturation.
package twiddle_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ROTATE, WRITE, DONE} state_t;

  typedef logic signed [15:0] q15_t;

  localparam int PHASE_W         = 32;     // one full turn == 2**PHASE_W
  localparam int CORDIC_GAIN_Q15 = 19898;  // round(0.6072529 * 32767)
  localparam int GUARD_BITS      = 2;      // fraction bits carried below Q1.15 inside the CORDIC
  localparam int SAT_IN_W        = 24;
  localparam int Q15_MAX         = 32767;
  localparam int Q15_MIN         = -32767;

  // atan(2^-i) / (2*pi) scaled to 2**PHASE_W per turn; beyond the table atan(x) ~= x.
  function automatic logic signed [PHASE_W-1:0] atan_turn(input logic [4:0] i);
    logic signed [PHASE_W-1:0] a;
    case (i)
      5'd0:    a = 32'sd536870912;
      5'd1:    a = 32'sd316933406;
      5'd2:    a = 32'sd167458907;
      5'd3:    a = 32'sd85004756;
      5'd4:    a = 32'sd42667331;
      5'd5:    a = 32'sd21354465;
      5'd6:    a = 32'sd10679838;
      5'd7:    a = 32'sd5340245;
      5'd8:    a = 32'sd2670163;
      5'd9:    a = 32'sd1335087;
      5'd10:   a = 32'sd667544;
      5'd11:   a = 32'sd333772;
      5'd12:   a = 32'sd166886;
      5'd13:   a = 32'sd83443;
      5'd14:   a = 32'sd41722;
      5'd15:   a = 32'sd20861;
      5'd16:   a = 32'sd10430;
      default: a = $signed(32'd683565276 >> i);
    endcase
    return a;
  endfunction

  function automatic q15_t sat_q15(input logic signed [SAT_IN_W-1:0] v);
    q15_t r;
    if (v > SAT_IN_W'(Q15_MAX))
      r = 16'sd32767;
    else if (v < SAT_IN_W'(Q15_MIN))
      r = -16'sd32767;
    else
      r = v[15:0];
    return r;
  endfunction

endpackage

// File: rtl/cordic_rot_iter.sv
// Iterative rotation-mode CORDIC: init loads (gain, 0, z0), each step performs one
// micro-rotation, so x/y converge to scaled cos/sin of z0 (turn units).
module cordic_rot_iter
  import twiddle_pkg::*;
#(
  parameter int CW = 19
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init,
  input  logic                      step,
  input  logic signed [PHASE_W-1:0] z0,
  output logic signed [CW-1:0]      x,
  output logic signed [CW-1:0]      y
);

  localparam logic signed [CW-1:0] X_INIT = CW'(CORDIC_GAIN_Q15 <<< GUARD_BITS);

  logic signed [PHASE_W-1:0] z;
  logic [4:0]                i;
  logic signed [CW-1:0]      x_sh;
  logic signed [CW-1:0]      y_sh;

  // Round-to-nearest shifts keep the accumulated bias well below one output LSB.
  always_comb begin
    x_sh = x >>> i;
    y_sh = y >>> i;
    if (i != 5'd0) begin
      x_sh = x_sh + $signed({{(CW-1){1'b0}}, x[i - 5'd1]});
      y_sh = y_sh + $signed({{(CW-1){1'b0}}, y[i - 5'd1]});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      z <= '0;
      i <= '0;
    end else if (init) begin
      x <= X_INIT;
      y <= '0;
      z <= z0;
      i <= '0;
    end else if (step) begin
      if (!z[PHASE_W-1]) begin
        x <= x - y_sh;
        y <= y + x_sh;
        z <= z - atan_turn(i);
      end else begin
        x <= x + y_sh;
        y <= y - x_sh;
        z <= z + atan_turn(i);
      end
      i <= i + 5'd1;
    end
  end

endmodule

// File: rtl/twiddle_gen_writer.sv
// Generates W_N^k for k = 0..DEPTH-1 with an iterative CORDIC and writes them in order
// through a valid/ready RAM port. Optional macro TWIDDLE_INV_EN adds an `inverse` input.
module twiddle_gen_writer
  import twiddle_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 4096,
  parameter  int ITER   = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef TWIDDLE_INV_EN
  input  logic              inverse,
`endif
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data
);

  localparam int HALF  = WIDTH / 2;
  // Two fraction guard bits plus one bit of headroom above the final magnitude.
  localparam int CW    = HALF + GUARD_BITS + 1;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic signed [CW-1:0] RND = CW'(1 <<< (GUARD_BITS - 1));

  state_t                    state;
  logic [ADDR_W-1:0]         k;
  logic [CNT_W-1:0]          iter_cnt;
  logic                      inv_sel;

  logic                      last_k;
  logic                      handshake;
  logic                      cordic_init;
  logic                      cordic_step;
  logic [ADDR_W-1:0]         load_k;
  logic signed [PHASE_W-1:0] z0;
  logic signed [CW-1:0]      cx;
  logic signed [CW-1:0]      cy;
  logic signed [CW-1:0]      c_val;
  logic signed [CW-1:0]      s_val;
  logic signed [CW-1:0]      re_val;
  logic signed [CW-1:0]      sin_val;
  logic signed [CW-1:0]      im_val;
  q15_t                      re_q;
  q15_t                      im_q;

`ifdef TWIDDLE_INV_EN
  logic inv_run;
  assign inv_sel = inv_run;
`else
  assign inv_sel = 1'b0;
`endif

  assign last_k      = (k == ADDR_W'(DEPTH - 1));
  assign handshake   = (state == WRITE) && wr_ready;
  assign load_k      = (state == IDLE) ? '0 : k + ADDR_W'(1);
  assign cordic_init = ((state == IDLE) && start) || (handshake && !last_k);
  // LOAD performs iteration 0, so the final iteration lands one cycle before WRITE.
  assign cordic_step = (state == LOAD) ||
                       ((state == ROTATE) && (iter_cnt != CNT_W'(ITER - 1)));
  assign z0          = {2'b00, load_k[ADDR_W-3:0], {(PHASE_W-ADDR_W){1'b0}}};

  cordic_rot_iter #(.CW(CW)) u_cordic (
    .clk  (clk),
    .rst  (rst),
    .init (cordic_init),
    .step (cordic_step),
    .z0   (z0),
    .x    (cx),
    .y    (cy)
  );

  always_comb begin
    c_val = (cx + RND) >>> GUARD_BITS;
    s_val = (cy + RND) >>> GUARD_BITS;
    case (k[ADDR_W-1:ADDR_W-2])
      2'd0:    begin re_val = c_val;  sin_val = s_val;  end
      2'd1:    begin re_val = -s_val; sin_val = c_val;  end
      2'd2:    begin re_val = -c_val; sin_val = -s_val; end
      default: begin re_val = s_val;  sin_val = -c_val; end
    endcase
    im_val = inv_sel ? sin_val : -sin_val;
    re_q   = sat_q15({{(SAT_IN_W-CW){re_val[CW-1]}}, re_val});
    im_q   = sat_q15({{(SAT_IN_W-CW){im_val[CW-1]}}, im_val});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      iter_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
`ifdef TWIDDLE_INV_EN
      inv_run  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            k     <= load_k;
            busy  <= 1'b1;
`ifdef TWIDDLE_INV_EN
            inv_run <= inverse;
`endif
          end
        end
        LOAD: begin
          state    <= ROTATE;
          iter_cnt <= '0;
        end
        ROTATE: begin
          if (iter_cnt == CNT_W'(ITER - 1)) begin
            state   <= WRITE;
            wr_en   <= 1'b1;
            wr_addr <= k;
            wr_data <= {HALF'(re_q), HALF'(im_q)};
          end else begin
            iter_cnt <= iter_cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          if (wr_ready) begin
            wr_en <= 1'b0;
            if (last_k) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= LOAD;
              k     <= load_k;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_gen_writer.sv
// Scoreboard bench for twiddle_gen_writer: expected factors come from $cos/$sin and are
// matched against every accepted write by an independent monitor.
module tb_twiddle_gen_writer;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 4096;
  localparam int ITER   = 16;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int TOL    = 2;
  localparam real PI    = 3.14159265358979323846;

  typedef struct {
    int addr;
    int re;
    int im;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              wr_ready = 1'b1;
  logic              busy;
  logic              done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
`ifdef TWIDDLE_INV_EN
  logic              inverse = 1'b0;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit   mon_inv = 0;
  bit   rand_mode = 0;
  bit   k7_stalled = 0;
  bit   stall_prev = 0;
  logic [ADDR_W-1:0] addr_prev;
  logic [WIDTH-1:0]  data_prev;
  int   stall_cycles = 0;
  int   hs_count = 0;
  int   first_hs_cyc = -1;
  int   start_cyc = 0;

  twiddle_gen_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ITER(ITER)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef TWIDDLE_INV_EN
    .inverse  (inverse),
`endif
    .busy     (busy),
    .done     (done),
    .wr_en    (wr_en),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Reference: W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), conjugated for the inverse table.
  task automatic push_run(input bit inv);
    for (int kk = 0; kk < DEPTH; kk++) begin
      exp_t e;
      real  a;
      a      = 2.0 * PI * real'(kk) / real'(DEPTH);
      e.addr = kk;
      e.re   = int'(32767.0 * $cos(a));
      e.im   = int'(-32767.0 * $sin(a));
      if (inv) e.im = -e.im;
      sb.push_back(e);
    end
  endtask

  // Monitor: pops one expectation per accepted write and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev)
        check("stall_hold", wr_en && (wr_addr == addr_prev) && (wr_data == data_prev),
              $sformatf("got en=%0b addr=%0d data=%h, required en=1 addr=%0d data=%h",
                        wr_en, wr_addr, wr_data, addr_prev, data_prev));
      if (wr_en && wr_ready) begin
        int re_a;
        int im_a;
        re_a = int'($signed(wr_data[WIDTH-1:WIDTH/2]));
        im_a = int'($signed(wr_data[WIDTH/2-1:0]));
        hs_count++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_write", 1'b0,
                $sformatf("got write addr=%0d data=%h, required no write", wr_addr, wr_data));
        end else begin
          mon_e = sb.pop_front();
          check("write_data",
                (int'(wr_addr) == mon_e.addr) && (iabs(re_a - mon_e.re) <= TOL) &&
                (iabs(im_a - mon_e.im) <= TOL),
                $sformatf("got addr=%0d re=%0d im=%0d, required addr=%0d re=%0d im=%0d (+/-%0d)",
                          wr_addr, re_a, im_a, mon_e.addr, mon_e.re, mon_e.im, TOL));
        end
        if (!mon_inv) begin
          int sre;
          int sim;
          bit hit;
          hit = 1'b1;
          case (int'(wr_addr))
            0:       begin sre = 32767;  sim = 0;      end
            512:     begin sre = 23170;  sim = -23170; end
            1024:    begin sre = 0;      sim = -32767; end
            2048:    begin sre = -32767; sim = 0;      end
            3072:    begin sre = 0;      sim = 32767;  end
            default: begin sre = 0; sim = 0; hit = 1'b0; end
          endcase
          if (hit)
            check($sformatf("point_k%0d", wr_addr),
                  (iabs(re_a - sre) <= TOL) && (iabs(im_a - sim) <= TOL),
                  $sformatf("got re=%0d im=%0d, required re=%0d im=%0d", re_a, im_a, sre, sim));
        end
      end
      stall_prev = wr_en && !wr_ready;
      if (stall_prev) stall_cycles++;
      addr_prev = wr_addr;
      data_prev = wr_data;
    end
  end

  // wr_ready driver: 5-cycle stall at k=7, random gaps early in the run (also outside WRITE).
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode && wr_en && (wr_addr == ADDR_W'(7)) && !k7_stalled) begin
        k7_stalled = 1;
        wr_ready   = 1'b0;
        repeat (5) @(posedge clk);
        #1 wr_ready = 1'b1;
      end else if (rand_mode && (!wr_en || (wr_addr < ADDR_W'(300)))) begin
        wr_ready = ($urandom_range(0, 3) != 0);
      end else begin
        wr_ready = 1'b1;
      end
    end
  end

  initial begin
    int  n;
    bit  seen;
    bit  late_start_done;
    int  extra;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", !busy && !done && !wr_en && (wr_addr == '0) && (wr_data == '0),
          $sformatf("got busy=%0b done=%0b en=%0b addr=%0d data=%h, required all 0",
                    busy, done, wr_en, wr_addr, wr_data));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Run 1: wr_ready held high, aborted by reset while k=100 is being written.
`ifdef TWIDDLE_INV_EN
    inverse = 1'b1;
    mon_inv = 1;
`endif
    push_run(mon_inv);
    first_hs_cyc = -1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef TWIDDLE_INV_EN
    inverse = 1'b0;
`endif
    check("busy_after_start", busy === 1'b1, $sformatf("got busy=%0b, required 1", busy));
    n = 0;
    seen = 0;
    while (n < 3000 && !seen) begin
      if (wr_en && (wr_addr == ADDR_W'(100))) seen = 1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check("reach_k100", seen, $sformatf("got no write at k=100 within %0d cycles, required one", n));
    check("first_latency", (first_hs_cyc - start_cyc) == ITER + 2,
          $sformatf("got %0d cycles, required %0d", first_hs_cyc - start_cyc, ITER + 2));
    #2 rst = 1'b1;
    #1;
    check("async_reset", !busy && !done && !wr_en && (wr_addr == '0) && (wr_data == '0),
          $sformatf("got busy=%0b done=%0b en=%0b addr=%0d data=%h, required all 0",
                    busy, done, wr_en, wr_addr, wr_data));
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_inv = 0;
    @(posedge clk);
    #1;

    // Run 2: restart from k=0 with random back-pressure, an extra start while busy and
    // a start coinciding with the final handshake.
    push_run(1'b0);
    stall_cycles = 0;
    hs_count = 0;
    rand_mode = 1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    n = 0;
    seen = 0;
    late_start_done = 0;
    while (n < DEPTH * (ITER + 2) + 5000 && !seen) begin
      if (done) seen = 1;
      else begin
        if (wr_en && (wr_addr == ADDR_W'(DEPTH - 1)) && !late_start_done) begin
          late_start_done = 1;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
        #1;
        n++;
      end
    end
    start = 1'b0;
    check("done_seen", seen, $sformatf("got no done within %0d cycles, required one", n));
    check("done_timing", (cyc - start_cyc) == DEPTH * (ITER + 2) + 1 + stall_cycles,
          $sformatf("got %0d cycles, required %0d (stalls %0d)", cyc - start_cyc,
                    DEPTH * (ITER + 2) + 1 + stall_cycles, stall_cycles));
    check("busy_at_done", !busy, $sformatf("got busy=%0b, required 0", busy));
    check("all_written", (hs_count == DEPTH) && (sb.size() == 0),
          $sformatf("got %0d writes with %0d pending, required %0d and 0",
                    hs_count, sb.size(), DEPTH));
    check("k7_stall_applied", k7_stalled, $sformatf("got k7_stalled=%0b, required 1", k7_stalled));
    rand_mode = 0;
    @(posedge clk);
    #1;
    check("done_pulse", !done && !busy,
          $sformatf("got done=%0b busy=%0b, required 0 0", done, busy));
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (wr_en || busy) extra++;
    end
    check("idle_after_done", extra == 0,
          $sformatf("got %0d active cycles, required 0", extra));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: got no completion by cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
